// File: rtl/incr_counter.sv
// incr_counter: registered up-counter with run control, terminal value (free-run or one-shot),
// and overflow detection; the sticky overflow logic is built only when INCR_COUNTER_OVF_EN is defined.

module Incr16 (
   input  logic [15:0] a,
   output logic [15:0] sum,
   output logic        carry
);
   // Each bit toggles when every lower bit is one; carry means the input was all-ones.
   always_comb begin
      logic ones_below;
      ones_below = 1'b1;
      sum        = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         sum[i]     = a[i] ^ ones_below;
         ones_below = ones_below & a[i];
      end
      carry = ones_below;
   end
endmodule

module Incr9 (
   input  logic [8:0] a,
   output logic [8:0] sum,
   output logic       carry
);
   // Same toggle rule as the 16-bit version, narrowed for 9-bit builds.
   always_comb begin
      logic ones_below;
      ones_below = 1'b1;
      sum        = 9'h000;
      for (int i = 0; i < 9; i++) begin
         sum[i]     = a[i] ^ ones_below;
         ones_below = ones_below & a[i];
      end
      carry = ones_below;
   end
endmodule

module incr_counter #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic             done_ack,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic             ovf
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] count_r, count_nxt_s;
   logic             oneshot_r, oneshot_nxt_s;
   logic             wrap_r, wrap_nxt_s;
   logic             ovf_r, ovf_nxt_s, ovf_set_s;
   logic             busy_r, done_r;
   logic [WIDTH-1:0] sum_s;
   logic             carry_s;

   generate
      if (WIDTH == 16) begin : g_incr16
         Incr16 u_incr (.a(count_r), .sum(sum_s), .carry(carry_s));
      end else if (WIDTH == 9) begin : g_incr9
         Incr9 u_incr (.a(count_r), .sum(sum_s), .carry(carry_s));
      end else begin : g_bad_width
         $error("incr_counter: WIDTH must be 9 or 16");
      end
   endgenerate

   // Next-state, next-count and flag computation; load outranks stop, stop outranks a step.
   always_comb begin
      state_nxt_s   = state_r;
      count_nxt_s   = count_r;
      oneshot_nxt_s = oneshot_r;
      wrap_nxt_s    = 1'b0;
      ovf_set_s     = 1'b0;
      if (load) begin
         count_nxt_s = load_val;
         if ((state_r == ST_RUN) && stop) begin
            state_nxt_s = ST_IDLE;
         end else begin
            state_nxt_s = state_r;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_nxt_s   = ST_RUN;
                  oneshot_nxt_s = oneshot;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_nxt_s = ST_IDLE;
               end else if (inc) begin
                  if (count_r == limit) begin
                     if (oneshot_r) begin
                        state_nxt_s = ST_DONE;
                     end else begin
                        count_nxt_s = {WIDTH{1'b0}};
                        wrap_nxt_s  = 1'b1;
                     end
                  end else if (carry_s) begin
                     count_nxt_s = {WIDTH{1'b0}};
                     ovf_set_s   = 1'b1;
                  end else begin
                     count_nxt_s = sum_s;
                  end
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_DONE: begin
               if (done_ack) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

`ifdef INCR_COUNTER_OVF_EN
   // Sticky overflow; a new overflow wins over a same-cycle clear.
   always_comb begin
      ovf_nxt_s = ovf_set_s | (ovf_r & ~clr_ovf);
   end
`else
   logic unused_ovf_s;
   assign unused_ovf_s = clr_ovf ^ ovf_set_s;

   // Overflow tracking compiled out; the flag stays low.
   always_comb begin
      ovf_nxt_s = 1'b0;
   end
`endif

   // State and output registers; busy/done are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         count_r   <= RESET_VAL;
         oneshot_r <= 1'b0;
         wrap_r    <= 1'b0;
         ovf_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         count_r   <= count_nxt_s;
         oneshot_r <= oneshot_nxt_s;
         wrap_r    <= wrap_nxt_s;
         ovf_r     <= ovf_nxt_s;
         busy_r    <= (state_nxt_s == ST_RUN);
         done_r    <= (state_nxt_s == ST_DONE);
      end
   end

   assign count = count_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign wrap  = wrap_r;
   assign ovf   = ovf_r;

endmodule
